// File: rtl/reversi_move_sequencer.sv
// Reversi move sequencer: validates a requested move, scans 8 directions through the board RAM,
// writes flips and the placed piece, then hands the turn over. Optional REVERSI_FLIP_COUNT_EN exposes flip_count.
module reversi_move_sequencer (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_move_valid,
    output logic       o_move_ready,
    input  logic [2:0] i_move_row,
    input  logic [2:0] i_move_col,
    input  logic       i_player,
    output logic       o_rd_en,
    output logic [5:0] o_rd_addr,
    input  logic [1:0] i_rd_data,
    output logic       o_wr_en,
    output logic [5:0] o_wr_addr,
    output logic [1:0] o_wr_data,
    output logic       o_next_turn,
    output logic       o_illegal,
    output logic       o_busy
`ifdef REVERSI_FLIP_COUNT_EN
    ,
    output logic [5:0] o_flip_count
`endif
);

    typedef enum logic [3:0] {
        IDLE,
        CHK_RD,
        CHK_EV,
        SCAN_RD,
        SCAN_EV,
        FLIP_WR,
        NEXT_DIR,
        PLACE,
        COMMIT,
        REJECT
    } state_t;

    localparam logic [1:0] D_NONE  = 2'd0;
    localparam logic [1:0] D_PLUS  = 2'd1;
    localparam logic [1:0] D_MINUS = 2'd2;

    // Direction 0..7 is N, NE, E, SE, S, SW, W, NW.
    function automatic logic [1:0] rowDelta(input logic [2:0] dir);
        case (dir)
            3'd0, 3'd1, 3'd7: rowDelta = D_MINUS;
            3'd3, 3'd4, 3'd5: rowDelta = D_PLUS;
            default:          rowDelta = D_NONE;
        endcase
    endfunction

    function automatic logic [1:0] colDelta(input logic [2:0] dir);
        case (dir)
            3'd1, 3'd2, 3'd3: colDelta = D_PLUS;
            3'd5, 3'd6, 3'd7: colDelta = D_MINUS;
            default:          colDelta = D_NONE;
        endcase
    endfunction

    // Widened so any step off the 0..7 range sets one of the top two bits.
    function automatic logic [4:0] stepCoord(input logic [2:0] base, input logic [1:0] delta,
                                             input logic [3:0] k);
        case (delta)
            D_PLUS:  stepCoord = {2'b00, base} + {1'b0, k};
            D_MINUS: stepCoord = {2'b00, base} - {1'b0, k};
            default: stepCoord = {2'b00, base};
        endcase
    endfunction

    function automatic logic [2:0] stepCoord3(input logic [2:0] base, input logic [1:0] delta,
                                              input logic [2:0] k);
        case (delta)
            D_PLUS:  stepCoord3 = base + k;
            D_MINUS: stepCoord3 = base - k;
            default: stepCoord3 = base;
        endcase
    endfunction

    state_t     r_state;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic       r_player;
    logic [2:0] r_dir;
    logic [3:0] r_k;
    logic [2:0] r_flipIdx;
`ifdef REVERSI_FLIP_COUNT_EN
    logic [5:0] r_total;
`else
    logic       r_total;
`endif

    logic [1:0] w_own;
    logic [1:0] w_opp;
    logic [2:0] w_nsDir;
    logic [3:0] w_nsK;
    logic [4:0] w_nsRow;
    logic [4:0] w_nsCol;
    logic       w_nsOn;
    logic [5:0] w_nsAddr;
    logic [2:0] w_flipDist;
    logic [5:0] w_flipAddr;

    assign w_own = {r_player, ~r_player};
    assign w_opp = ~w_own;

    // Coordinates of the next scan read, whichever state is about to issue it.
    assign w_nsDir  = (r_state == CHK_EV)   ? 3'd0 :
                      (r_state == NEXT_DIR) ? r_dir + 3'd1 : r_dir;
    assign w_nsK    = (r_state == SCAN_EV) ? r_k + 4'd1 : 4'd1;
    assign w_nsRow  = stepCoord(r_row, rowDelta(w_nsDir), w_nsK);
    assign w_nsCol  = stepCoord(r_col, colDelta(w_nsDir), w_nsK);
    assign w_nsOn   = (w_nsRow[4:3] == 2'b00) && (w_nsCol[4:3] == 2'b00);
    assign w_nsAddr = {w_nsRow[2:0], w_nsCol[2:0]};

    // Flipped cells lie strictly between target and the bounding own piece, so they never leave the board.
    assign w_flipDist = (r_state == SCAN_EV) ? 3'd1 : r_flipIdx + 3'd1;
    assign w_flipAddr = {stepCoord3(r_row, rowDelta(r_dir), w_flipDist),
                         stepCoord3(r_col, colDelta(r_dir), w_flipDist)};

    assign o_move_ready = (r_state == IDLE);
    assign o_busy       = (r_state != IDLE);

    // Strobes are registered on entry to the state that owns them, so each lasts exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_player    <= 1'b0;
            r_dir       <= '0;
            r_k         <= '0;
            r_flipIdx   <= '0;
            r_total     <= '0;
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_next_turn <= 1'b0;
            o_illegal   <= 1'b0;
`ifdef REVERSI_FLIP_COUNT_EN
            o_flip_count <= '0;
`endif
        end else begin
            o_rd_en     <= 1'b0;
            o_wr_en     <= 1'b0;
            o_next_turn <= 1'b0;
            o_illegal   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_move_valid) begin
                        r_row     <= i_move_row;
                        r_col     <= i_move_col;
                        r_player  <= i_player;
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= {i_move_row, i_move_col};
                        r_state   <= CHK_RD;
                    end
                end
                CHK_RD: r_state <= CHK_EV;
                CHK_EV: begin
                    if (i_rd_data[1] ^ i_rd_data[0]) begin
                        o_illegal <= 1'b1;
                        r_state   <= REJECT;
                    end else begin
                        r_dir     <= 3'd0;
                        r_k       <= 4'd1;
                        r_total   <= '0;
                        o_rd_en   <= w_nsOn;
                        o_rd_addr <= w_nsAddr;
                        r_state   <= SCAN_RD;
                    end
                end
                // A missing read strobe means this step left the board.
                SCAN_RD: r_state <= o_rd_en ? SCAN_EV : NEXT_DIR;
                SCAN_EV: begin
                    if (i_rd_data == w_opp) begin
                        r_k       <= r_k + 4'd1;
                        o_rd_en   <= w_nsOn;
                        o_rd_addr <= w_nsAddr;
                        r_state   <= SCAN_RD;
                    end else if ((i_rd_data == w_own) && (r_k >= 4'd2)) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= w_flipAddr;
                        o_wr_data <= w_own;
                        r_flipIdx <= 3'd1;
`ifdef REVERSI_FLIP_COUNT_EN
                        r_total   <= r_total + {2'b00, r_k - 4'd1};
`else
                        r_total   <= 1'b1;
`endif
                        r_state   <= FLIP_WR;
                    end else begin
                        r_state <= NEXT_DIR;
                    end
                end
                FLIP_WR: begin
                    if (({1'b0, r_flipIdx} + 4'd1) < r_k) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= w_flipAddr;
                        o_wr_data <= w_own;
                        r_flipIdx <= r_flipIdx + 3'd1;
                    end else begin
                        r_state <= NEXT_DIR;
                    end
                end
                NEXT_DIR: begin
                    if (r_dir != 3'd7) begin
                        r_dir     <= r_dir + 3'd1;
                        r_k       <= 4'd1;
                        o_rd_en   <= w_nsOn;
                        o_rd_addr <= w_nsAddr;
                        r_state   <= SCAN_RD;
                    end else if (|r_total) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= {r_row, r_col};
                        o_wr_data <= w_own;
                        r_state   <= PLACE;
                    end else begin
                        o_illegal <= 1'b1;
                        r_state   <= REJECT;
                    end
                end
                PLACE: begin
                    o_next_turn <= 1'b1;
`ifdef REVERSI_FLIP_COUNT_EN
                    o_flip_count <= r_total;
`endif
                    r_state <= COMMIT;
                end
                COMMIT:  r_state <= IDLE;
                REJECT:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reversi_move_sequencer.sv
// Directed testbench for reversi_move_sequencer with a 1-cycle-latency board RAM model.
// Checks flip_count only when REVERSI_FLIP_COUNT_EN is defined.
module tb_reversi_move_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       moveValid = 1'b0;
    logic       moveReady;
    logic [2:0] moveRow = '0;
    logic [2:0] moveCol = '0;
    logic       player = 1'b0;
    logic       rdEn;
    logic [5:0] rdAddr;
    logic [1:0] rdData;
    logic       wrEn;
    logic [5:0] wrAddr;
    logic [1:0] wrData;
    logic       nextTurn;
    logic       illegal;
    logic       busy;
`ifdef REVERSI_FLIP_COUNT_EN
    logic [5:0] flipCount;
`endif

    reversi_move_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_move_valid (moveValid),
        .o_move_ready (moveReady),
        .i_move_row   (moveRow),
        .i_move_col   (moveCol),
        .i_player     (player),
        .o_rd_en      (rdEn),
        .o_rd_addr    (rdAddr),
        .i_rd_data    (rdData),
        .o_wr_en      (wrEn),
        .o_wr_addr    (wrAddr),
        .o_wr_data    (wrData),
        .o_next_turn  (nextTurn),
        .o_illegal    (illegal),
        .o_busy       (busy)
`ifdef REVERSI_FLIP_COUNT_EN
        ,
        .o_flip_count (flipCount)
`endif
    );

    always #5 clk = ~clk;

    logic [1:0] board  [64];
    logic [1:0] preset [64];
    logic       loadBoard = 1'b0;

    // Board RAM: whole-board preload, 1-cycle read latency.
    always @(posedge clk) begin
        if (loadBoard) board <= preset;
        else if (wrEn) board[wrAddr] <= wrData;
        if (rdEn) rdData <= board[rdAddr];
    end

    int         ntCount = 0;
    int         ilCount = 0;
    logic [7:0] writeLog [$];
    logic [5:0] readLog  [$];

    always @(negedge clk) begin
        if (nextTurn) ntCount++;
        if (illegal) ilCount++;
        if (wrEn) writeLog.push_back({wrAddr, wrData});
        if (rdEn) readLog.push_back(rdAddr);
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] writeAt(input int idx);
        if (idx < writeLog.size()) return writeLog[idx];
        return 8'bx;
    endfunction

    function automatic logic [5:0] readAt(input int idx);
        if (idx < readLog.size()) return readLog[idx];
        return 6'bx;
    endfunction

    task automatic clearPreset();
        for (int i = 0; i < 64; i++) preset[i] = 2'b00;
    endtask

    task automatic presetOpening();
        clearPreset();
        preset[27] = 2'b10;
        preset[28] = 2'b01;
        preset[35] = 2'b01;
        preset[36] = 2'b10;
    endtask

    task automatic presetRow0();
        clearPreset();
        for (int i = 1; i <= 6; i++) preset[i] = 2'b10;
        preset[7] = 2'b01;
    endtask

    task automatic loadPreset();
        @(negedge clk);
        loadBoard = 1'b1;
        @(negedge clk);
        loadBoard = 1'b0;
    endtask

    // Presents one move; returns 1 time unit after the accepting edge and flips 'player' to prove it is latched.
    task automatic applyStimulus(input logic [2:0] row, input logic [2:0] col, input logic p);
        @(negedge clk);
        moveValid = 1'b1;
        moveRow   = row;
        moveCol   = col;
        player    = p;
        @(posedge clk);
        #1;
        moveValid = 1'b0;
        player    = ~p;
    endtask

    task automatic waitDone(output logic done);
        int start;
        start = ntCount + ilCount;
        done  = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #1;
            if (ntCount + ilCount > start) done = 1'b1;
        end
    endtask

    initial begin
        int         ws;
        int         rs;
        int         nt0;
        int         il0;
        logic       done;
        logic [5:0] expReads [7];

        repeat (3) @(negedge clk);
        checkOutput("reset_move_ready", moveReady, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rd_en", rdEn, 0);
        checkOutput("reset_wr_en", wrEn, 0);
        checkOutput("reset_next_turn", nextTurn, 0);
        checkOutput("reset_illegal", illegal, 0);
`ifdef REVERSI_FLIP_COUNT_EN
        checkOutput("reset_flip_count", flipCount, 0);
`endif
        resetn = 1'b1;

        $display("[TB] opening board, black plays (2,3)");
        presetOpening();
        loadPreset();
        ws = writeLog.size(); nt0 = ntCount; il0 = ilCount;
        applyStimulus(3'd2, 3'd3, 1'b0);
        waitDone(done);
        checkOutput("s1_done", done, 1);
        checkOutput("s1_next_turn_count", ntCount - nt0, 1);
        checkOutput("s1_illegal_count", ilCount - il0, 0);
        checkOutput("s1_write_count", writeLog.size() - ws, 2);
        checkOutput("s1_write0", writeAt(ws), {6'd27, 2'b01});
        checkOutput("s1_write1", writeAt(ws + 1), {6'd19, 2'b01});
`ifdef REVERSI_FLIP_COUNT_EN
        checkOutput("s1_flip_count", flipCount, 1);
`endif
        @(negedge clk);
        checkOutput("s1_ready_after", moveReady, 1);
        checkOutput("s1_board27", board[27], 2'b01);

        $display("[TB] opening board, black plays occupied (3,3)");
        presetOpening();
        loadPreset();
        ws = writeLog.size(); nt0 = ntCount; il0 = ilCount;
        applyStimulus(3'd3, 3'd3, 1'b0);
        @(negedge clk);
        checkOutput("s2_c1_rd_en", rdEn, 1);
        checkOutput("s2_c1_rd_addr", rdAddr, 27);
        checkOutput("s2_c1_ready", moveReady, 0);
        @(negedge clk);
        checkOutput("s2_c2_illegal", illegal, 0);
        checkOutput("s2_c2_busy", busy, 1);
        @(negedge clk);
        checkOutput("s2_c3_illegal", illegal, 1);
        checkOutput("s2_c3_ready", moveReady, 0);
        @(negedge clk);
        checkOutput("s2_c4_ready", moveReady, 1);
        checkOutput("s2_c4_illegal", illegal, 0);
        checkOutput("s2_write_count", writeLog.size() - ws, 0);
        checkOutput("s2_next_turn_count", ntCount - nt0, 0);
        checkOutput("s2_illegal_count", ilCount - il0, 1);

        $display("[TB] opening board, black plays corner (0,0)");
        ws = writeLog.size(); rs = readLog.size(); nt0 = ntCount; il0 = ilCount;
        applyStimulus(3'd0, 3'd0, 1'b0);
        waitDone(done);
        checkOutput("s3_done", done, 1);
        checkOutput("s3_illegal_count", ilCount - il0, 1);
        checkOutput("s3_next_turn_count", ntCount - nt0, 0);
        checkOutput("s3_write_count", writeLog.size() - ws, 0);
        checkOutput("s3_read_count", readLog.size() - rs, 4);
`ifdef REVERSI_FLIP_COUNT_EN
        checkOutput("s3_flip_count_held", flipCount, 1);
`endif

        $display("[TB] row 0 run of white, black plays (0,0)");
        presetRow0();
        loadPreset();
        ws = writeLog.size(); nt0 = ntCount; il0 = ilCount;
        applyStimulus(3'd0, 3'd0, 1'b0);
        waitDone(done);
        checkOutput("s4_done", done, 1);
        checkOutput("s4_next_turn_count", ntCount - nt0, 1);
        checkOutput("s4_write_count", writeLog.size() - ws, 7);
        for (int i = 0; i < 7; i++) begin
            logic [5:0] expAddr;
            expAddr = (i < 6) ? 6'(i + 1) : 6'd0;
            checkOutput($sformatf("s4_write%0d", i), writeAt(ws + i), {expAddr, 2'b01});
        end
`ifdef REVERSI_FLIP_COUNT_EN
        checkOutput("s4_flip_count", flipCount, 6);
`endif
        @(negedge clk);
        checkOutput("s4_board0", board[0], 2'b01);

        $display("[TB] corner (7,7) hemmed by white at edges");
        clearPreset();
        preset[62] = 2'b10;
        preset[54] = 2'b10;
        preset[55] = 2'b10;
        loadPreset();
        ws = writeLog.size(); rs = readLog.size(); nt0 = ntCount; il0 = ilCount;
        applyStimulus(3'd7, 3'd7, 1'b0);
        waitDone(done);
        checkOutput("s5_done", done, 1);
        checkOutput("s5_illegal_count", ilCount - il0, 1);
        checkOutput("s5_next_turn_count", ntCount - nt0, 0);
        checkOutput("s5_write_count", writeLog.size() - ws, 0);
        checkOutput("s5_read_count", readLog.size() - rs, 7);
        expReads = '{6'd63, 6'd55, 6'd47, 6'd62, 6'd61, 6'd54, 6'd45};
        for (int i = 0; i < 7; i++)
            checkOutput($sformatf("s5_read%0d", i), readAt(rs + i), expReads[i]);

        $display("[TB] reset during flip writes");
        presetRow0();
        loadPreset();
        ws = writeLog.size(); nt0 = ntCount; il0 = ilCount;
        applyStimulus(3'd0, 3'd0, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (wrEn) done = 1'b1;
        end
        checkOutput("s6_flip_seen", done, 1);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("s6_wr_en", wrEn, 0);
        checkOutput("s6_busy", busy, 0);
        checkOutput("s6_ready", moveReady, 1);
        checkOutput("s6_next_turn", nextTurn, 0);
        checkOutput("s6_rd_en", rdEn, 0);
`ifdef REVERSI_FLIP_COUNT_EN
        checkOutput("s6_flip_count", flipCount, 0);
`endif
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("s6_next_turn_count", ntCount - nt0, 0);
        checkOutput("s6_illegal_count", ilCount - il0, 0);
        checkOutput("s6_write_count", writeLog.size() - ws, 1);
        checkOutput("s6_write0", writeAt(ws), {6'd1, 2'b01});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
